// File: rtl/sam_pkg.sv
// -----------------------------------------------------------------------------
// sam_pkg
// Shared definitions for the SAM video fetch path: the VDG display mode
// encoding (SAM V2..V0), the per-mode row geometry lookup, the page shift
// applied to the display offset, and the fetch FSM state type.
// -----------------------------------------------------------------------------
package sam_pkg;

   // The display offset F6..F0 counts 512-byte pages.
   localparam int PAGE_SHIFT = 9;

   typedef enum logic [2:0] {
      SAM_V_ALPHA = 3'b000,
      SAM_V_G1C   = 3'b001,
      SAM_V_G1R   = 3'b010,
      SAM_V_G2C   = 3'b011,
      SAM_V_G2R   = 3'b100,
      SAM_V_G3C   = 3'b101,
      SAM_V_G3R   = 3'b110,
      SAM_V_DMA   = 3'b111
   } sam_mode_e;

   typedef struct packed {
      logic [5:0] bytes_per_row;   // 16 or 32
      logic [3:0] line_repeat;     // scan lines per row of bytes, 1..12
   } sam_geom_t;

   typedef enum logic {
      FETCH_IDLE = 1'b0,
      FETCH_WAIT = 1'b1
   } fetch_state_e;

   // Row geometry per mode. SAM_V_DMA is linear and never rewinds a row, so
   // its entry only has to give a harmless value.
   function automatic sam_geom_t geom(input sam_mode_e m);
      sam_geom_t g;
      g.bytes_per_row = 6'd32;
      g.line_repeat   = 4'd1;
      case (m)
         SAM_V_ALPHA: begin g.bytes_per_row = 6'd32; g.line_repeat = 4'd12; end
         SAM_V_G1C:   begin g.bytes_per_row = 6'd16; g.line_repeat = 4'd3;  end
         SAM_V_G1R:   begin g.bytes_per_row = 6'd32; g.line_repeat = 4'd3;  end
         SAM_V_G2C:   begin g.bytes_per_row = 6'd16; g.line_repeat = 4'd2;  end
         SAM_V_G2R:   begin g.bytes_per_row = 6'd32; g.line_repeat = 4'd2;  end
         SAM_V_G3C:   begin g.bytes_per_row = 6'd16; g.line_repeat = 4'd1;  end
         SAM_V_G3R:   begin g.bytes_per_row = 6'd32; g.line_repeat = 4'd1;  end
         default:     begin g.bytes_per_row = 6'd32; g.line_repeat = 4'd1;  end
      endcase
      return g;
   endfunction

endpackage

// File: rtl/sam_vid_addr_ctr.sv
// -----------------------------------------------------------------------------
// sam_vid_addr_ctr
// Video address counter. Tracks the current row base, the column within the
// row and the scan-line repeat count, driven by VDG field/horizontal sync
// falling edges and by accepted byte requests from the fetcher.
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   mode           SAM V2..V0 (sampled into mode_q on fs/hs falling edges)
//   disp_offset    SAM F6..F0, display base in 512-byte pages
//   hs_n, fs_n     VDG syncs, active low, synchronous to clk
//   advance        a request consumed the current address this cycle
//   addr           current video address, row_base + col
// -----------------------------------------------------------------------------
module sam_vid_addr_ctr
   import sam_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [2:0]        mode,
   input  logic [6:0]        disp_offset,
   input  logic              hs_n,
   input  logic              fs_n,
   input  logic              advance,
   output logic [ADDR_W-1:0] addr
);

   logic              prev_hs_q, prev_hs_d;
   logic              prev_fs_q, prev_fs_d;
   sam_mode_e         mode_q, mode_d;
   logic [ADDR_W-1:0] row_base_q, row_base_d;
   logic [ADDR_W-1:0] col_q, col_d;
   logic [3:0]        line_cnt_q, line_cnt_d;

   sam_geom_t         g;
   logic              fs_fall;
   logic              hs_fall;
   logic              linear;
   logic [ADDR_W-1:0] col_mask;
   logic [ADDR_W-1:0] col_inc;
   logic [ADDR_W-1:0] field_base;

   assign addr = row_base_q + col_q;

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      prev_hs_d  = hs_n;
      prev_fs_d  = fs_n;
      mode_d     = mode_q;
      row_base_d = row_base_q;
      line_cnt_d = line_cnt_q;

      g          = geom(mode_q);
      fs_fall    = prev_fs_q & ~fs_n;
      hs_fall    = prev_hs_q & ~hs_n;
      linear     = (mode_q == SAM_V_DMA);
      col_mask   = ADDR_W'(g.bytes_per_row) - ADDR_W'(1);
      col_inc    = advance ? col_q + ADDR_W'(1) : col_q;
      field_base = ADDR_W'(disp_offset) << PAGE_SHIFT;

      // Outside linear mode the column wraps within the row.
      col_d = linear ? col_inc : (col_inc & col_mask);

      if (fs_fall) begin
         // Field start wins over a coincident line start.
         row_base_d = field_base;
         col_d      = '0;
         line_cnt_d = '0;
         mode_d     = sam_mode_e'(mode);
      end else if (hs_fall) begin
         mode_d = sam_mode_e'(mode);
         col_d  = '0;
         if (linear) begin
            // Fold the column into the base so addressing carries on where
            // the line left off, including a request taken this cycle.
            row_base_d = row_base_q + col_inc;
            line_cnt_d = '0;
         end else if (line_cnt_q == g.line_repeat - 4'd1) begin
            row_base_d = row_base_q + ADDR_W'(g.bytes_per_row);
            line_cnt_d = '0;
         end else begin
            line_cnt_d = line_cnt_q + 4'd1;
         end
      end
   end

   // Sync edge registers reset high so a sync held low through reset does
   // not register as a falling edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_hs_q  <= 1'b1;
         prev_fs_q  <= 1'b1;
         mode_q     <= SAM_V_ALPHA;
         row_base_q <= '0;
         col_q      <= '0;
         line_cnt_q <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling the
         // pre-edge values, independent of statement order.
         prev_hs_q  <= prev_hs_d;
         prev_fs_q  <= prev_fs_d;
         mode_q     <= mode_d;
         row_base_q <= row_base_d;
         col_q      <= col_d;
         line_cnt_q <= line_cnt_d;
      end
   end

endmodule

// File: rtl/sam_vid_fetch.sv
// -----------------------------------------------------------------------------
// sam_vid_fetch
// Video-side address generator and RAM fetcher for the CoCo2 core. Walks
// video RAM following the VDG syncs, fetches each requested byte from the RAM
// arbiter over a req/ack handshake, and delivers it to the VDG with a
// one-cycle valid strobe. One further request may wait in a pending slot
// while a fetch is in flight; a request beyond that is dropped and flagged.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   mode, disp_offset     SAM V2..V0 and F6..F0 from the SAM registers
//   hs_n, fs_n            VDG syncs, active low
//   byte_req              VDG asks for the next display byte (1-cycle pulse)
//   mem_req, mem_addr     RAM read request, held with stable address to ack
//   mem_ack, mem_data     RAM read completion, data valid with the ack
//   vdata, vdata_valid    byte to the VDG, valid pulses when vdata updates
//   overrun               sticky: a request was dropped with the slot full
// -----------------------------------------------------------------------------
module sam_vid_fetch
   import sam_pkg::*;
#(
   parameter int ADDR_W     = 16,
   parameter int PEND_DEPTH = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [2:0]        mode,
   input  logic [6:0]        disp_offset,
   input  logic              hs_n,
   input  logic              fs_n,
   input  logic              byte_req,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [7:0]        mem_data,
   output logic [7:0]        vdata,
   output logic              vdata_valid,
   output logic              overrun
);

   // The pending slot is a single register; no other depth is built.
   if (PEND_DEPTH != 1) begin : g_bad_pend_depth
      $error("sam_vid_fetch supports PEND_DEPTH = 1 only");
   end

   fetch_state_e      state_q, state_d;
   logic              mem_req_q, mem_req_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              pend_valid_q, pend_valid_d;
   logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
   logic [7:0]        vdata_q, vdata_d;
   logic              vdata_valid_q, vdata_valid_d;
   logic              overrun_q, overrun_d;

   logic              advance;
   logic [ADDR_W-1:0] cur_addr;

   sam_vid_addr_ctr #(
      .ADDR_W (ADDR_W)
   ) u_addr_ctr (
      .clk         (clk),
      .reset_n     (reset_n),
      .mode        (mode),
      .disp_offset (disp_offset),
      .hs_n        (hs_n),
      .fs_n        (fs_n),
      .advance     (advance),
      .addr        (cur_addr)
   );

   assign mem_req     = mem_req_q;
   assign mem_addr    = mem_addr_q;
   assign vdata       = vdata_q;
   assign vdata_valid = vdata_valid_q;
   assign overrun     = overrun_q;

   always_comb begin
      state_d       = state_q;
      mem_req_d     = mem_req_q;
      mem_addr_d    = mem_addr_q;
      pend_valid_d  = pend_valid_q;
      pend_addr_d   = pend_addr_q;
      vdata_d       = vdata_q;
      vdata_valid_d = 1'b0;
      overrun_d     = overrun_q;
      advance       = 1'b0;

      case (state_q)
         FETCH_IDLE: begin
            if (pend_valid_q) begin
               // Older buffered request goes first; a new request arriving
               // now takes the slot it frees.
               mem_addr_d   = pend_addr_q;
               mem_req_d    = 1'b1;
               state_d      = FETCH_WAIT;
               pend_valid_d = 1'b0;
               if (byte_req) begin
                  pend_addr_d  = cur_addr;
                  pend_valid_d = 1'b1;
                  advance      = 1'b1;
               end
            end else if (byte_req) begin
               mem_addr_d = cur_addr;
               mem_req_d  = 1'b1;
               state_d    = FETCH_WAIT;
               advance    = 1'b1;
            end
         end

         FETCH_WAIT: begin
            if (mem_ack) begin
               vdata_d       = mem_data;
               vdata_valid_d = 1'b1;
               mem_req_d     = 1'b0;
               state_d       = FETCH_IDLE;
            end
            if (byte_req) begin
               if (!pend_valid_q) begin
                  pend_addr_d  = cur_addr;
                  pend_valid_d = 1'b1;
                  advance      = 1'b1;
               end else begin
                  // Dropped: the column stays put so the VDG can re-ask.
                  overrun_d = 1'b1;
               end
            end
         end

         default: begin
            state_d   = FETCH_IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= FETCH_IDLE;
         mem_req_q     <= 1'b0;
         mem_addr_q    <= '0;
         pend_valid_q  <= 1'b0;
         pend_addr_q   <= '0;
         vdata_q       <= '0;
         vdata_valid_q <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         mem_req_q     <= mem_req_d;
         mem_addr_q    <= mem_addr_d;
         pend_valid_q  <= pend_valid_d;
         pend_addr_q   <= pend_addr_d;
         vdata_q       <= vdata_d;
         vdata_valid_q <= vdata_valid_d;
         overrun_q     <= overrun_d;
      end
   end

endmodule

// File: tb/tb_sam_vid_fetch.sv
// -----------------------------------------------------------------------------
// tb_sam_vid_fetch
// Scoreboard bench for sam_vid_fetch. Expected addresses are queued when a
// byte request is driven and compared when the RAM model sees mem_req; the RAM
// model queues the data it returns, compared when vdata_valid pulses.
// -----------------------------------------------------------------------------
module tb_sam_vid_fetch;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  mode;
   logic [6:0]  disp_offset;
   logic        hs_n;
   logic        fs_n;
   logic        byte_req;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [7:0]  mem_data;
   logic [7:0]  vdata;
   logic        vdata_valid;
   logic        overrun;

   int          n_checks  = 0;
   int          n_errors  = 0;
   int          ack_delay = 0;
   int          n_valid   = 0;

   logic [15:0] exp_addr_q[$];
   logic [7:0]  exp_data_q[$];

   always #5 clk = ~clk;

   sam_vid_fetch dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .mode        (mode),
      .disp_offset (disp_offset),
      .hs_n        (hs_n),
      .fs_n        (fs_n),
      .byte_req    (byte_req),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_data    (mem_data),
      .vdata       (vdata),
      .vdata_valid (vdata_valid),
      .overrun     (overrun)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [7:0] data_of(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic fs_pulse();
      fs_n = 1'b0; tick(); fs_n = 1'b1; tick();
   endtask

   task automatic hs_pulse();
      hs_n = 1'b0; tick(); hs_n = 1'b1; tick();
   endtask

   // One request, then enough idle cycles for a zero-delay fetch to finish.
   task automatic req(input logic [15:0] a);
      exp_addr_q.push_back(a);
      byte_req = 1'b1; tick(); byte_req = 1'b0; tick(3);
   endtask

   // RAM model: checks the address of each new request, then acks after
   // ack_delay cycles unless reset intervenes.
   initial begin : ram_model
      logic [15:0] a;
      bit          aborted;
      mem_ack  = 1'b0;
      mem_data = 8'h00;
      forever begin
         @(negedge clk);
         mem_ack = 1'b0;
         if (reset_n && mem_req) begin
            a = mem_addr;
            if (exp_addr_q.size() == 0)
               check("mem_addr_queued", 32'(exp_addr_q.size()), 32'd1);
            else
               check("mem_addr", 32'(a), 32'(exp_addr_q.pop_front()));
            aborted = 1'b0;
            for (int k = 0; k < ack_delay; k++) begin
               @(negedge clk);
               if (!reset_n) aborted = 1'b1;
               else if (!aborted) check("mem_addr_stable", 32'({mem_req, mem_addr}), 32'({1'b1, a}));
            end
            if (!aborted && reset_n) begin
               mem_ack  = 1'b1;
               mem_data = data_of(a);
               exp_data_q.push_back(data_of(a));
            end
         end
      end
   end

   initial begin : vdata_monitor
      forever begin
         @(negedge clk);
         if (vdata_valid) begin
            n_valid++;
            if (exp_data_q.size() == 0)
               check("vdata_queued", 32'(exp_data_q.size()), 32'd1);
            else
               check("vdata", 32'(vdata), 32'(exp_data_q.pop_front()));
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      int guard;
      int valid_base;

      reset_n = 1'b0; mode = 3'b000; disp_offset = 7'h00;
      hs_n = 1'b1; fs_n = 1'b1; byte_req = 1'b0;
      tick(3);
      reset_n = 1'b1;
      tick(2);
      check("rst_mem_req",     32'(mem_req),     32'd0);
      check("rst_mem_addr",    32'(mem_addr),    32'd0);
      check("rst_vdata",       32'(vdata),       32'd0);
      check("rst_vdata_valid", 32'(vdata_valid), 32'd0);
      check("rst_overrun",     32'(overrun),     32'd0);

      // Alpha mode: 32 bytes per row, each row shown on 12 lines.
      mode = 3'b000; disp_offset = 7'h02;
      fs_pulse();
      for (int i = 0; i < 32; i++) req(16'h0400 + 16'(i));
      hs_pulse();
      for (int i = 0; i < 32; i++) req(16'h0400 + 16'(i));
      repeat (10) hs_pulse();
      req(16'h0400);
      hs_pulse();
      req(16'h0420);

      // 16 bytes per row, one line per row; 17th request wraps the column.
      mode = 3'b101; disp_offset = 7'h00;
      fs_pulse();
      for (int l = 0; l < 3; l++) begin
         for (int i = 0; i < 16; i++) req(16'(l * 16 + i));
         if (l < 2) hs_pulse();
      end
      req(16'h0020);

      // 32 bytes per row from the top page; rows roll over 0xFFFF.
      mode = 3'b110; disp_offset = 7'h7F;
      fs_pulse();
      req(16'hFE00); req(16'hFE01);
      hs_pulse(); req(16'hFE20);
      hs_pulse(); req(16'hFE40);
      repeat (14) hs_pulse();
      req(16'h0000); req(16'h0001);

      // Linear mode: no column mask, line start carries the column forward.
      mode = 3'b111; disp_offset = 7'h01;
      fs_pulse();
      for (int i = 0; i < 40; i++) req(16'h0200 + 16'(i));
      hs_pulse();
      req(16'h0228);

      // Slow RAM: second request buffered, third dropped.
      mode = 3'b110; disp_offset = 7'h10;
      fs_pulse();
      check("overrun_before", 32'(overrun), 32'd0);
      valid_base = n_valid;
      ack_delay  = 5;
      exp_addr_q.push_back(16'h2000);
      exp_addr_q.push_back(16'h2001);
      byte_req = 1'b1; tick();
      byte_req = 1'b0; tick();
      byte_req = 1'b1; tick(2);
      byte_req = 1'b0;
      tick(25);
      check("overrun_set",     32'(overrun),              32'd1);
      check("overrun_fetches", 32'(n_valid - valid_base), 32'd2);
      ack_delay = 0;
      req(16'h2002);
      check("overrun_sticky",  32'(overrun),              32'd1);

      // Coincident field and line start: field wins, line count restarts.
      mode = 3'b100; disp_offset = 7'h05;
      fs_pulse();
      hs_pulse();
      req(16'h0A00);
      disp_offset = 7'h08;
      hs_n = 1'b0; fs_n = 1'b0; tick();
      hs_n = 1'b1; fs_n = 1'b1; tick();
      req(16'h1000);
      hs_pulse(); req(16'h1000);
      hs_pulse(); req(16'h1020);

      // Reset in the middle of a fetch with the pending slot full.
      mode = 3'b000; disp_offset = 7'h0C;
      fs_pulse();
      ack_delay = 5;
      exp_addr_q.push_back(16'h1800);
      byte_req = 1'b1; tick(); byte_req = 1'b0; tick();
      byte_req = 1'b1; tick(); byte_req = 1'b0;
      guard = 0;
      while (!mem_req && guard < 10) begin tick(); guard++; end
      check("mem_req_before_rst", 32'(mem_req), 32'd1);
      #2 reset_n = 1'b0;
      #1 check("mem_req_async_rst", 32'(mem_req), 32'd0);
      check("overrun_async_rst",    32'(overrun), 32'd0);
      tick(2);
      exp_addr_q.delete();
      #2 reset_n = 1'b1;
      tick(3);
      check("mem_req_after_rst", 32'(mem_req), 32'd0);
      ack_delay = 0;
      disp_offset = 7'h03;
      fs_pulse();
      req(16'h0600);
      req(16'h0601);

      tick(10);
      check("addr_queue_drained", 32'(exp_addr_q.size()), 32'd0);
      check("data_queue_drained", 32'(exp_data_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/sam_vid_fetch.md
Name: sam_vid_fetch

Overview:
- Video-side address generator and RAM fetcher for the CoCo2 core. It is the reader of the display setup that the CPU writes into the SAM registers: display offset F6..F0 and VDG mode V2..V0.
- Walks video RAM per the VDG timing (HS#/FS#), requests each byte from the RAM arbiter over a req/ack handshake, and hands fetched bytes to the VDG with a valid strobe.

Parameters:
- ADDR_W, 16, video address width; address arithmetic wraps modulo 2^ADDR_W.
- PEND_DEPTH, 1, outstanding byte requests buffered while a fetch is in flight; fixed at 1.

Ports:
- clk  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- mode  in  3  SAM V2..V0 from the SAM register file.
- disp_offset  in  7  SAM F6..F0, display base in 512-byte pages.
- hs_n  in  1  VDG horizontal sync, active low, synchronous to clk.
- fs_n  in  1  VDG field sync, active low, synchronous to clk.
- byte_req  in  1  one-cycle pulse from the VDG requesting the next display byte.
- mem_req  out  1  RAM read request, held until mem_ack.
- mem_addr  out  16  RAM read address, stable while mem_req is high.
- mem_ack  in  1  one-cycle pulse; mem_data is valid in the same cycle.
- mem_data  in  8  RAM read data.
- vdata  out  8  byte delivered to the VDG.
- vdata_valid  out  1  one-cycle pulse when vdata updates.
- overrun  out  1  sticky flag: a byte_req arrived while the fetcher was busy and the pending slot was full.

Behaviour:
- Reset values: all outputs 0; internal row_base, col and line_cnt 0; state IDLE; hs/fs edge registers 1.
- Edge detection: fs_fall = prev_fs_n & ~fs_n; hs_fall = prev_hs_n & ~hs_n.
- Mode geometry, as (bytes_per_row, line_repeat):
  - 000 = (32,12)
  - 001 = (16,3)
  - 010 = (32,3)
  - 011 = (16,2)
  - 100 = (32,2)
  - 101 = (16,1)
  - 110 = (32,1)
  - 111 = linear mode: no row rewind.
- mode is latched into mode_q on fs_fall and on hs_fall; geometry always comes from mode_q.
- On fs_fall: row_base <= {disp_offset, 9'b0}, col <= 0, line_cnt <= 0, mode_q <= mode.
  - fs_fall has priority over a simultaneous hs_fall.
- On hs_fall, with no fs_fall in the same cycle:
  - If line_cnt == line_repeat-1: row_base <= row_base + bytes_per_row (mod 2^16) and line_cnt <= 0.
  - Otherwise line_cnt <= line_cnt + 1.
  - col <= 0 in both cases.
  - In mode 111: row_base <= row_base + col and col <= 0, so addressing continues linearly.
- Address of an accepted request: row_base + col.
  - col then increments, wrapping within bytes_per_row (mask 0x0F or 0x1F).
  - In mode 111, col is 16-bit and unmasked.
- Fetch FSM:
  - IDLE: on byte_req (or a set pending bit), capture the address into mem_addr, raise mem_req, go to WAIT.
  - WAIT: hold mem_req and mem_addr. On mem_ack, vdata <= mem_data, pulse vdata_valid the next cycle, drop mem_req, go to IDLE.
  - The pending request, if any, is issued from IDLE the cycle after return; minimum two-cycle gap between mem_req assertions.
- Request buffering:
  - byte_req while in WAIT with the pending slot empty: the address is computed and stored in the pending slot.
  - byte_req while in WAIT with the pending slot full: the request is dropped, col does not advance, overrun <= 1.
  - overrun clears only on reset.
- Field boundary: fs_fall does not abort an in-flight fetch; the current fetch and any pending one complete with their old addresses.
- mem_ack in IDLE is ignored.
- Asynchronous reset mid-fetch: mem_req drops immediately and the pending slot clears.

Decomposition:
- Shared package sam_pkg:
  - mode enum, SAM_V_ALPHA = 3'b000 .. SAM_V_DMA = 3'b111.
  - Function geom(mode) returning bytes_per_row and line_repeat.
  - PAGE_SHIFT = 9.
- One natural sub-module, sam_vid_addr_ctr: row_base, col, line_cnt and the edge detectors. The fetch FSM and pending slot stay in the top module.

Test Plan:
- Mode 000, disp_offset=7'h02, fs_fall, 32 byte_req, hs_fall, 32 byte_req -> mem_addr 0x0400..0x041F twice; row_base becomes 0x0420 only after the 12th hs_fall.
- Mode 101, offset 0, fs_fall, 3 lines of 16 requests -> addresses 0x0000-0x000F, 0x0010-0x001F, 0x0020-0x002F; line_cnt stays 0.
- Mode 110, offset 7'h7F, run 3 rows -> row bases 0xFE00, 0xFE20, 0xFE40; 16-bit wrap checked with offset 7'h7F plus 0x200 rows -> addresses roll past 0xFFFF to 0x0000.
- mem_ack delayed 5 cycles, byte_req at cycles 0, 2, 3 -> two fetches complete in order with vdata_valid pulses; third request dropped and overrun=1; col advanced by 2.
- fs_fall and hs_fall in the same cycle -> row_base = {disp_offset, 9'b0}, line_cnt=0.
- reset_n pulsed low while mem_req=1 -> mem_req=0 in the same cycle; after release the next fs_fall restarts at the disp_offset base.
